// File: rtl/imem_program_loader.sv
// Streams 32-bit instruction words into a 16-bit halfword IMEM, pads the rest with NOPs,
// writes a terminal self-loop at the top and releases the CPU. Optional: LOADER_CHECKSUM_EN.
module imem_program_loader #(
  parameter int          IMEM_ADDRESS_WIDTH = 6,
  parameter logic [31:0] NOP_WORD           = 32'h0000_0013,
  parameter logic [31:0] LOOP_WORD          = 32'h0000_0063,
  parameter logic [15:0] C_NOP              = 16'h0001
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [31:0]                   s_data_i,
  input  logic                          s_last_i,
  output logic                          imem_we_o,
  output logic [IMEM_ADDRESS_WIDTH-1:0] imem_addr_o,
  output logic [15:0]                   imem_wdata_o,
  output logic                          cpu_hold_o,
  output logic                          done_o,
  output logic                          overflow_o,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]                   checksum_o,
`endif
  output logic [IMEM_ADDRESS_WIDTH:0]   load_count_o
);

  localparam int AW    = IMEM_ADDRESS_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] TAIL_ADDR = AW'(DEPTH - 2);
  localparam logic [AW-1:0] TOP_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   PTR_LIMIT = (AW+1)'(DEPTH - 2);

  typedef enum logic [2:0] {
    LOAD, LOAD_HI, ALIGN, FILL_LO, FILL_HI, TAIL_LO, TAIL_HI, DONE
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [15:0]   hi_q;
  logic          hi_last_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic          hold_q;
  logic          done_q;
  logic          ovf_q;
  logic [AW:0]   cnt_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   csum_q;
`endif

  logic          is_comp;
  logic          fit_c;
  logic          fit_f;
  logic [AW:0]   ptr_x;
  logic [AW-1:0] ptr_inc;

  assign is_comp = (s_data_i[1:0] != 2'b11);
  assign ptr_x   = {1'b0, ptr_q};
  assign ptr_inc = ptr_q + 1'b1;
  assign fit_c   = ptr_x < PTR_LIMIT;
  assign fit_f   = (ptr_x + 1'b1) < PTR_LIMIT;

  // Where to go once the program body ends with the pointer at p.
  function automatic state_e after_load(input logic [AW-1:0] p);
    if (p[0])                 return ALIGN;
    else if (p == TAIL_ADDR)  return TAIL_LO;
    else                      return FILL_LO;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= LOAD;
      ptr_q     <= '0;
      hi_q      <= '0;
      hi_last_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (s_valid_i) begin
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q + (is_comp ? {16'h0000, s_data_i[15:0]} : s_data_i);
`endif
            if (is_comp && fit_c) begin
              we_q    <= 1'b1;
              addr_q  <= ptr_q;
              wdata_q <= s_data_i[15:0];
              ptr_q   <= ptr_inc;
              cnt_q   <= cnt_q + 1'b1;
              if (s_last_i) state_q <= after_load(ptr_inc);
            end else if (!is_comp && fit_f) begin
              we_q      <= 1'b1;
              addr_q    <= ptr_q;
              wdata_q   <= s_data_i[15:0];
              ptr_q     <= ptr_inc;
              hi_q      <= s_data_i[31:16];
              hi_last_q <= s_last_i;
              state_q   <= LOAD_HI;
            end else begin
              // Oversized program: swallow words until the stream ends.
              ovf_q <= 1'b1;
              if (s_last_i) state_q <= after_load(ptr_q);
            end
          end
        end
        LOAD_HI: begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          wdata_q <= hi_q;
          ptr_q   <= ptr_inc;
          cnt_q   <= cnt_q + (AW+1)'(2);
          state_q <= hi_last_q ? after_load(ptr_inc) : LOAD;
        end
        ALIGN: begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          wdata_q <= C_NOP;
          ptr_q   <= ptr_inc;
          state_q <= after_load(ptr_inc);
        end
        FILL_LO: begin
          if (ptr_q == TAIL_ADDR) begin
            state_q <= TAIL_LO;
          end else begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= NOP_WORD[15:0];
            ptr_q   <= ptr_inc;
            state_q <= FILL_HI;
          end
        end
        FILL_HI: begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          wdata_q <= NOP_WORD[31:16];
          ptr_q   <= ptr_inc;
          state_q <= (ptr_inc == TAIL_ADDR) ? TAIL_LO : FILL_LO;
        end
        TAIL_LO: begin
          we_q    <= 1'b1;
          addr_q  <= TAIL_ADDR;
          wdata_q <= LOOP_WORD[15:0];
          state_q <= TAIL_HI;
        end
        TAIL_HI: begin
          we_q    <= 1'b1;
          addr_q  <= TOP_ADDR;
          wdata_q <= LOOP_WORD[31:16];
          state_q <= DONE;
        end
        DONE: begin
          if (start_i) begin
            ptr_q   <= '0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
            state_q <= LOAD;
          end else begin
            // First DONE cycle is the one after the top-of-memory write is presented.
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign s_ready_o    = (state_q == LOAD);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign load_count_o = cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_o   = csum_q;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader; expected IMEM writes are queued by a reference model.
module tb_imem_program_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          overflow;
  logic [AW:0]   load_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  imem_program_loader #(.IMEM_ADDRESS_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
    .s_last_i     (s_last),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .cpu_hold_o   (cpu_hold),
    .done_o       (done),
    .overflow_o   (overflow),
`ifdef LOADER_CHECKSUM_EN
    .checksum_o   (checksum),
`endif
    .load_count_o (load_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];
  logic [15:0] mem [DEPTH];

  int          m_ptr;
  int          m_cnt;
  logic        m_ovf;
  logic [31:0] m_csum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_ovf = 1'b0; m_csum = '0;
  endtask

  task automatic push(input int a, input logic [15:0] d);
    exp_q.push_back({6'(a), d});
  endtask

  task automatic model_word(input logic [31:0] w, input logic last);
    logic comp;
    comp = (w[1:0] != 2'b11);
    m_csum = m_csum + (comp ? {16'h0000, w[15:0]} : w);
    if (comp && m_ptr < DEPTH - 2) begin
      push(m_ptr, w[15:0]); m_ptr++; m_cnt++;
    end else if (!comp && m_ptr + 1 < DEPTH - 2) begin
      push(m_ptr, w[15:0]); push(m_ptr + 1, w[31:16]); m_ptr += 2; m_cnt += 2;
    end else begin
      m_ovf = 1'b1;
    end
    if (last) begin
      if (m_ptr % 2 == 1) begin push(m_ptr, 16'h0001); m_ptr++; end
      while (m_ptr < DEPTH - 2) begin
        push(m_ptr, 16'h0013); push(m_ptr + 1, 16'h0000); m_ptr += 2;
      end
      push(DEPTH - 2, 16'h0063);
      push(DEPTH - 1, 16'h0000);
    end
  endtask

  // Scoreboard side: every presented write must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0d:%h expected=none", imem_addr, imem_wdata);
      end
      if (exp_q.size() != 0) begin
        logic [21:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({imem_addr, imem_wdata} === e) else begin
          errors++;
          $error("FAIL write observed=%0d:%h expected=%0d:%h", imem_addr, imem_wdata, e[21:16], e[15:0]);
        end
      end
      mem[imem_addr] = imem_wdata;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] w, input logic last);
    int n;
    model_word(w, last);
    s_valid = 1'b1; s_data = w; s_last = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    assert (n < 100) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=<100", n);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 400) begin @(negedge clk); n++; end
    checks++;
    assert (n < 400) else begin
      errors++;
      $error("FAIL %s_done_timeout observed=%0d expected=<400", tag, n);
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_hold"}, cpu_hold, 1'b0);
    chk({tag, "_ready"}, s_ready, 1'b0);
    chk({tag, "_count"}, load_count, m_cnt);
    chk({tag, "_ovf"}, overflow, m_ovf);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, checksum, m_csum);
`endif
  endtask

  task automatic reload(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_reset();
    @(negedge clk);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ready"}, s_ready, 1'b1);
    chk({tag, "_count"}, load_count, 0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, s_ready, 1'b1);
    chk({tag, "_we"}, imem_we, 1'b0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_count"}, load_count, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Two full words; s_ready drops for one cycle after a full-word handshake.
    send(32'h0050_0093, 1'b0);
    @(negedge clk); chk("t1_ready_low", s_ready, 1'b0);
    @(negedge clk); chk("t1_ready_back", s_ready, 1'b1);
    @(posedge clk); #1;
    send(32'h00A0_0113, 1'b1);
    wait_done("t1");
    chk("t1_m0", mem[0], 16'h0093);
    chk("t1_m3", mem[3], 16'h00A0);
    chk("t1_m4", mem[4], 16'h0013);
    chk("t1_m61", mem[61], 16'h0000);
    chk("t1_m62", mem[62], 16'h0063);
    chk("t1_count4", load_count, 4);

    // Compressed then full with last forces an alignment C.NOP; start mid-load is ignored.
    reload("r1");
    send(32'h0000_4505, 1'b0);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    chk("t2_start_ignored_hold", cpu_hold, 1'b1);
    send(32'h0000_0513, 1'b1);
    wait_done("t2");
    chk("t2_m2", mem[2], 16'h0000);
    chk("t2_m3", mem[3], 16'h0001);
    chk("t2_m4", mem[4], 16'h0013);

    // Exactly DEPTH-2 halfwords: no fill writes, no overflow.
    reload("r2");
    for (int i = 0; i < 31; i++) send(32'h1000_0003 + (i << 8), i == 30);
    wait_done("t3");
    chk("t3_count62", load_count, 62);
    chk("t3_ovf0", overflow, 1'b0);

    // One word too many: dropped, overflow sticky.
    reload("r3");
    for (int i = 0; i < 32; i++) send(32'h2000_0007 + (i << 8), i == 31);
    wait_done("t4");
    chk("t4_ovf1", overflow, 1'b1);
    chk("t4_count62", load_count, 62);

    // Reset in the middle of a load, then a fresh one-word image.
    reload("r4");
    for (int i = 0; i < 3; i++) send(32'h3000_0093 + (i << 12), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    exp_q.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send(32'h0070_0393, 1'b1);
    wait_done("t5");
    chk("t5_m1", mem[1], 16'h0070);

`ifdef LOADER_CHECKSUM_EN
    reload("r5");
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b1);
    wait_done("t6");
    chk("t6_checksum", checksum, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Synthesizable boot loader for the RISC-V core's 16-bit-halfword instruction memory.
- Accepts a valid/ready stream of 32-bit instruction words. Writes compressed instructions as one halfword and full instructions as two.
- Pads the remaining space with NOPs and writes a terminal self-loop at the top of memory.
- Holds the CPU in reset until the image is complete; can reload on request.

Parameters:
IMEM_ADDRESS_WIDTH, 6, halfword address width; DEPTH = 2**IMEM_ADDRESS_WIDTH halfwords (even, >= 8)
NOP_WORD, 32'h00000013, 32-bit fill instruction (addi x0,x0,0)
LOOP_WORD, 32'h00000063, terminal instruction (beq x0,x0,0)
C_NOP, 16'h0001, compressed NOP used for alignment

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  single-cycle reload request
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts word
s_data  in  32  instruction word; [1:0]!=2'b11 means compressed, only [15:0] used
s_last  in  1  final word of program
imem_we  out  1  halfword write enable
imem_addr  out  IMEM_ADDRESS_WIDTH  halfword write address
imem_wdata  out  16  halfword write data
cpu_hold  out  1  high = keep CPU in reset
done  out  1  image complete
overflow  out  1  program exceeded DEPTH-2 halfwords; sticky until next load
load_count  out  IMEM_ADDRESS_WIDTH+1  halfwords written from stream

Behaviour:
- Reset (rst low, async) enters LOAD with the pointer at 0.
  - Output values: s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, overflow=0, load_count=0.
  - A reset mid-load abandons the image with no further writes. Memory contents are not restored.
- All writes are registered: exactly one halfword per cycle, one cycle after the decision.
- States: LOAD, LOAD_HI, ALIGN, FILL_LO, FILL_HI, TAIL_LO, TAIL_HI, DONE.
- LOAD (s_ready=1). A handshake (s_valid&&s_ready) behaves as follows:
  - Compressed word with ptr < DEPTH-2: write s_data[15:0] at ptr; ptr++; load_count++.
  - Full word with ptr+1 < DEPTH-2: write [15:0] at ptr; latch [31:16]; go to LOAD_HI.
  - Word that does not fit: no write, overflow=1. Keep accepting and discarding until s_last.
  - s_last on an accepted compressed or dropped word: go to ALIGN if ptr is odd, else FILL_LO.
- LOAD_HI (s_ready=0):
  - Write the latched upper half at ptr; ptr++; load_count += 2 for the word.
  - If that word carried s_last, go to ALIGN/FILL_LO by parity; otherwise return to LOAD.
- ALIGN: write C_NOP at the odd ptr; ptr++; go to FILL_LO.
- FILL_LO / FILL_HI:
  - If ptr == DEPTH-2, skip straight to TAIL_LO.
  - Otherwise write NOP_WORD[15:0], then NOP_WORD[31:16]; repeat.
- TAIL_LO: write LOOP_WORD[15:0] at DEPTH-2. TAIL_HI: write LOOP_WORD[31:16] at DEPTH-1.
- DONE:
  - done=1 and cpu_hold=0, both from the cycle after the final write; s_ready=0.
- start:
  - Honoured only in DONE: clears done, overflow, load_count and ptr; sets cpu_hold=1; next state LOAD.
  - Ignored in every other state.
- s_valid without s_last in DONE is ignored (no handshake).
- A program exactly filling DEPTH-2 halfwords goes directly to TAIL after the last write. No FILL writes, overflow=0.
- An empty program is not expressible: at least one word carrying s_last is required.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined: adds output checksum[31:0]. It is the 32-bit wrapping sum of every accepted s_data word, including dropped overflow words; compressed words contribute zero-extended [15:0]. Reset and start clear it to 0. Value is final when done rises.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- DEPTH=64; stream full 0x00500093, then 0x00A00113 with s_last -> writes addr0=0093, 1=0050, 2=0113, 3=00A0. Addr 4..61 alternate 0013/0000, 62=0063, 63=0000. load_count=4, done=1, cpu_hold=0, overflow=0.
- Compressed 0x4505 then full 0x00000513 with s_last -> 0=4505, 1=0513, 2=0000, 3=C_NOP 0001. Fill starts at 4. s_ready low for exactly one cycle after the full-word handshake.
- 31 full words (62 halfwords) with last carrying s_last -> no fill writes, 62=0063, 63=0000, overflow=0. A 32nd full word -> dropped, overflow=1, load_count=62.
- Assert rst low mid-stream after 3 words -> next cycle all outputs at reset values, s_ready=1. A fresh 1-word load then completes correctly.
- In DONE pulse start, with start also pulsed once mid-load -> mid-load pulse ignored; DONE pulse reloads with cpu_hold=1 and done=0 the following cycle.
- LOADER_CHECKSUM_EN: words 0xFFFFFFFF, then 0x00000002 with s_last -> checksum=0x00000001 at done.
